// File: rtl/reset_sequencer_pkg.sv
// Shared constants and state encoding for the reset sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package reset_sequencer_pkg;

  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_HOLD_CYCLES = 16;

  // Completed-sequence counter saturates here instead of wrapping.
  localparam logic [7:0] COUNT_MAX = 8'd255;

  typedef enum logic [2:0] {
    ST_ASSERT = 3'd0,
    ST_SYNC   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_SWRST  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/reset_sync_chain.sv
// Reset deassertion synchronizer: async-set flop chain shifting in zeros.
// Latency: last stage clears SYNC_STAGES edges after rst falls.
// Backpressure: none; free-running shift once rst is low.
module reset_sync_chain
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  output logic settle
);

  localparam logic TIE_LO = 1'b0;

  logic [SYNC_STAGES-1:0] chain;

  // Chain is forced to all-ones asynchronously and drains toward zero one stage per edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], TIE_LO};
    end
  end

  // High when the value about to load into the final stage is zero, i.e. this
  // edge is the one on which the last stage reads 0.
  assign settle = ~|(chain << 1);

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: async assert, synchronized + held deassert, software reset handshake.
// Latency: rst_out falls SYNC_STAGES+HOLD_CYCLES edges after rst falls; sw reset holds HOLD_CYCLES edges.
// Backpressure: sw_req is a level held until sw_ack; a new request needs sw_req low for a cycle.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_req,
  output logic       sw_ack,
  output logic       rst_out,
  output logic       rst_done,
  output logic [7:0] rst_count
);

  localparam int             CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  seq_state_t    state;
  logic [CW-1:0] hold_cnt;
  logic          done_q;
  logic          ack_q;
  // Cleared when a software sequence completes; re-armed once sw_req is seen low.
  logic          armed;
  logic          sync_settle;
  logic          seq_done;

  // Power-up values keep rst_out high and the counter at zero before any clock or reset.
  (* init = "1" *) logic       rst_out_q = 1'b1;
  (* init = "0" *) logic [7:0] count_q   = 8'd0;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .settle(sync_settle)
  );

  // A hold or software sequence finishes on this edge.
  assign seq_done = !rst && ((state == ST_HOLD) || (state == ST_SWRST)) && (hold_cnt == '0);

  // Sequencing FSM with registered rst_out / rst_done / sw_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ASSERT;
      hold_cnt  <= '0;
      rst_out_q <= 1'b1;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      armed     <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      if (!sw_req) begin
        armed <= 1'b1;
      end
      case (state)
        ST_ASSERT: begin
          state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (sync_settle) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state     <= ST_RUN;
            rst_out_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - CNT_ONE;
          end
        end
        ST_RUN: begin
          if (sw_req && armed) begin
            state     <= ST_SWRST;
            hold_cnt  <= HOLD_LOAD;
            rst_out_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        ST_SWRST: begin
          if (hold_cnt == '0) begin
            state     <= ST_RUN;
            rst_out_q <= 1'b0;
            done_q    <= 1'b1;
            ack_q     <= 1'b1;
            armed     <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - CNT_ONE;
          end
        end
        default: begin
          state     <= ST_ASSERT;
          rst_out_q <= 1'b1;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  // Completed-sequence count survives rst; saturates at COUNT_MAX.
  always_ff @(posedge clk) begin
    if (seq_done && (count_q != COUNT_MAX)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign rst_out   = rst_out_q;
  assign rst_done  = done_q;
  assign sw_ack    = ack_q;
  assign rst_count = count_q;

endmodule
